// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package imem_loader_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects big-endian bytes into 32-bit words; word/word_valid are combinational
// so the word is available in the same cycle its last byte is accepted.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0]  cnt;
  logic [23:0] sr;

  assign word       = {sr, byte_in};
  assign word_valid = en && (cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      sr  <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      sr  <= {sr[15:0], byte_in};
      cnt <= cnt + 2'd1;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Frame loader: header (word count), payload words written to InstMem, XOR checksum;
// holds the core in reset until a verified image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_wren,
  output logic [ADDR_W-1:0] im_address,
  output logic [31:0]       im_data,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int N_W = 8 * HDR_BYTES;

  state_t          state, state_nxt;
  logic [N_W-1:0]  words_left;
  logic [N_W-1:0]  hdr_n;
  logic [7:0]      xor_acc;
  logic            accept, start_ok, pk_en, word_valid;
  logic [31:0]     word;

  assign busy      = (state == HDR_HI) || (state == HDR_LO) || (state == DATA) || (state == CHK);
  assign in_ready  = busy;
  assign done      = (state == DONE);
  assign err       = (state == ERR);
  assign cpu_rst_n = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign pk_en     = accept && (state == DATA);
  // Full word count as seen while the low header byte is on the bus.
  assign hdr_n     = {words_left[N_W-9:0], in_data};

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_ok),
    .en         (pk_en),
    .byte_in    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = HDR_HI;
      HDR_HI:          if (accept) state_nxt = HDR_LO;
      HDR_LO:          if (accept) state_nxt = (hdr_n == '0) ? CHK : DATA;
      DATA:            if (word_valid && words_left == N_W'(1)) state_nxt = CHK;
      CHK:             if (accept) state_nxt = (in_data == xor_acc) ? DONE : ERR;
      default:         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      words_left <= '0;
      xor_acc    <= '0;
      im_wren    <= 1'b0;
      im_address <= '0;
      im_data    <= '0;
    end else begin
      state   <= state_nxt;
      im_wren <= word_valid;
      if (word_valid) im_data <= word;
      // Address advances after the write strobe so it is stable during the write.
      if (start_ok)     im_address <= '0;
      else if (im_wren) im_address <= im_address + ADDR_W'(1);
      if (start_ok)   xor_acc <= '0;
      else if (pk_en) xor_acc <= xor_acc ^ in_data;
      if (accept && (state == HDR_HI || state == HDR_LO))
        words_left <= hdr_n;
      else if (word_valid)
        words_left <= words_left - N_W'(1);
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames with known words and hand-computed checksums.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, im_wren, cpu_rst_n, busy, done, err;
  logic [15:0] im_address;
  logic [31:0] im_data;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_wren(im_wren), .im_address(im_address), .im_data(im_data),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (im_wren === 1'b1) begin
      wr_addr.push_back(im_address);
      wr_data.push_back(im_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    int k;
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      miscompares++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Header plus the first nbytes payload bytes of words w[0..n-1].
  task automatic send_payload(input logic [31:0] w[8], input int n, input int nbytes,
                              input bit gaps);
    logic [15:0] nn;
    logic [31:0] cur;
    nn = 16'(n);
    send_byte(nn[15:8]);
    send_byte(nn[7:0]);
    for (int k = 0; k < nbytes; k++) begin
      if (gaps) idle($urandom_range(0, 2));
      cur = w[k/4];
      send_byte(cur[31-8*(k%4) -: 8]);
    end
  endtask

  task automatic test_reset();
    #12;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    vectors++; if (im_wren !== 1'b0) begin miscompares++; $display("FAIL rst_im_wren got %b want 0", im_wren); end
    vectors++; if ({busy, done, err} !== 3'b000) begin miscompares++; $display("FAIL rst_flags got %b want 000", {busy, done, err}); end
    vectors++; if (im_address !== 16'h0) begin miscompares++; $display("FAIL rst_addr got %h want 0000", im_address); end
    vectors++; if (im_data !== 32'h0) begin miscompares++; $display("FAIL rst_data got %h want 0", im_data); end
    vectors++; if (cpu_rst_n !== 1'b0) begin miscompares++; $display("FAIL rst_cpu_rst_n got %b want 0", cpu_rst_n); end
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    vectors++; if ({busy, in_ready, cpu_rst_n} !== 3'b000) begin miscompares++; $display("FAIL idle_hold got %b want 000", {busy, in_ready, cpu_rst_n}); end
  endtask

  task automatic test_basic();
    logic [31:0] w[8];
    w = '{default: 32'h0};
    w[0] = 32'h20080005; w[1] = 32'hAC080000;
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    vectors++; if ({busy, in_ready, done} !== 3'b110) begin miscompares++; $display("FAIL basic_started got %b want 110", {busy, in_ready, done}); end
    send_payload(w, 2, 8, 1'b0);
    // Last write lands in the first CHK cycle.
    vectors++; if (im_wren !== 1'b1 || im_address !== 16'd1) begin miscompares++; $display("FAIL basic_last_wren got wren=%b addr=%h want 1/0001", im_wren, im_address); end
    send_byte(8'h89); // 20^08^00^05^AC^08^00^00
    vectors++; if ({done, cpu_rst_n, err, busy} !== 4'b1100) begin miscompares++; $display("FAIL basic_done got %b want 1100", {done, cpu_rst_n, err, busy}); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_ready_done got %b want 0", in_ready); end
    vectors++; if (wr_addr.size() !== 2) begin miscompares++; $display("FAIL basic_nwrites got %0d want 2", wr_addr.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (wr_addr[i] !== 16'(i) || wr_data[i] !== w[i]) begin
          miscompares++;
          $display("FAIL basic_write%0d got %h@%h want %h@%h", i, wr_data[i], wr_addr[i], w[i], 16'(i));
        end
      end
    end
  endtask

  task automatic test_bad_cks();
    logic [31:0] w[8];
    w = '{default: 32'h0};
    w[0] = 32'h20080005; w[1] = 32'hAC080000;
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    vectors++; if (done !== 1'b0 || cpu_rst_n !== 1'b0) begin miscompares++; $display("FAIL restart_clears got done=%b cpu=%b want 0/0", done, cpu_rst_n); end
    send_payload(w, 2, 8, 1'b0);
    send_byte(8'h00);
    vectors++; if ({err, done, cpu_rst_n, busy} !== 4'b1000) begin miscompares++; $display("FAIL bad_cks got %b want 1000", {err, done, cpu_rst_n, busy}); end
    vectors++; if (wr_addr.size() !== 2 || wr_data[1] !== 32'hAC080000) begin miscompares++; $display("FAIL bad_cks_writes got %0d writes want 2", wr_addr.size()); end
    idle(2);
    vectors++; if (err !== 1'b1 || cpu_rst_n !== 1'b0) begin miscompares++; $display("FAIL err_hold got err=%b cpu=%b want 1/0", err, cpu_rst_n); end
    pulse_start();
    vectors++; if (err !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL err_restart got err=%b busy=%b want 0/1", err, busy); end
    send_payload(w, 2, 8, 1'b0);
    send_byte(8'h89);
    vectors++; if ({done, cpu_rst_n, err} !== 3'b110) begin miscompares++; $display("FAIL recover got %b want 110", {done, cpu_rst_n, err}); end
  endtask

  task automatic test_zero();
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    vectors++; if ({done, cpu_rst_n, err} !== 3'b110) begin miscompares++; $display("FAIL zero_done got %b want 110", {done, cpu_rst_n, err}); end
    idle(2);
    vectors++; if (wr_addr.size() !== 0) begin miscompares++; $display("FAIL zero_writes got %0d want 0", wr_addr.size()); end
  endtask

  task automatic test_gaps();
    logic [31:0] w[8];
    logic [31:0] cur;
    w = '{default: 32'h0};
    w[0] = 32'h12345678; w[1] = 32'hDEADBEEF; w[2] = 32'h00FF00FF;
    for (int pass = 0; pass < 2; pass++) begin
      wr_addr.delete(); wr_data.delete();
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h03);
      for (int k = 0; k < 12; k++) begin
        if (pass == 1) idle($urandom_range(0, 2));
        if (pass == 1 && k == 5) begin
          pulse_start();
          vectors++; if (busy !== 1'b1 || im_address !== 16'd1) begin miscompares++; $display("FAIL start_ignored got busy=%b addr=%h want 1/0001", busy, im_address); end
        end
        cur = w[k/4];
        send_byte(cur[31-8*(k%4) -: 8]);
      end
      if (pass == 1) idle(2);
      send_byte(8'h2A); // 08 ^ 22 ^ 00 per word
      vectors++; if ({done, cpu_rst_n, err} !== 3'b110) begin miscompares++; $display("FAIL gaps%0d_done got %b want 110", pass, {done, cpu_rst_n, err}); end
      vectors++; if (wr_addr.size() !== 3) begin miscompares++; $display("FAIL gaps%0d_nwrites got %0d want 3", pass, wr_addr.size()); end
      else begin
        for (int i = 0; i < 3; i++) begin
          vectors++;
          if (wr_addr[i] !== 16'(i) || wr_data[i] !== w[i]) begin
            miscompares++;
            $display("FAIL gaps%0d_write%0d got %h@%h want %h@%h", pass, i, wr_data[i], wr_addr[i], w[i], 16'(i));
          end
        end
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [31:0] w[8];
    w = '{default: 32'h0};
    w[0] = 32'h01020304; w[1] = 32'h05060708; w[2] = 32'h090A0B0C; w[3] = 32'h0D0E0F10;
    pulse_start();
    send_payload(w, 4, 6, 1'b0);
    vectors++; if (im_address !== 16'd1 || busy !== 1'b1) begin miscompares++; $display("FAIL mid_pre got addr=%h busy=%b want 0001/1", im_address, busy); end
    #2 rst = 1'b0;
    #1;
    vectors++; if ({busy, in_ready, cpu_rst_n, done, err} !== 5'b00000) begin miscompares++; $display("FAIL mid_rst_flags got %b want 00000", {busy, in_ready, cpu_rst_n, done, err}); end
    vectors++; if (im_address !== 16'h0) begin miscompares++; $display("FAIL mid_rst_addr got %h want 0000", im_address); end
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1; in_data = 8'hFF;
    idle(3);
    in_valid = 1'b0;
    vectors++; if (busy !== 1'b0 || cpu_rst_n !== 1'b0) begin miscompares++; $display("FAIL mid_needs_start got busy=%b cpu=%b want 0/0", busy, cpu_rst_n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_cks();
    test_zero();
    test_gaps();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
